// File: rtl/pipe5_datapath_pkg.sv
// Shared constants for the pipe5 MIPS-subset datapath: opcodes, functs, ALU codes,
// the control bundle and the ROM / data-RAM initial images.
package pipe5_datapath_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [3:0] aluc;
    logic       aluimm;
  } ctrl_t;

  // prog 0 is the standard load program; prog 1 exercises sw, $0 writes and an unknown opcode
  function automatic logic [31:0] imem_word(input int prog, input logic [5:0] idx);
    logic [31:0] w;
    w = '0;
    if (prog == 0) begin
      case (idx)
        6'd0: w = 32'h8C220000;
        6'd1: w = 32'h8C230004;
        6'd2: w = 32'h8C240008;
        6'd3: w = 32'h8C25000C;
        6'd4: w = 32'h004A3020;
        default: w = '0;
      endcase
    end else begin
      case (idx)
        6'd0: w = 32'h8C020000;
        6'd1: w = 32'h20000005;
        6'd2: w = 32'hFC000000;
        6'd4: w = 32'hAC020010;
        6'd5: w = 32'h8C070010;
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  function automatic logic [31:0] dmem_init(input logic [5:0] idx);
    logic [31:0] w;
    case (idx)
      6'd0: w = 32'hA00000AA;
      6'd1: w = 32'h10000011;
      6'd2: w = 32'h20000022;
      6'd3: w = 32'h30000033;
      6'd4: w = 32'h40000044;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pipe5_datapath_if.sv
// Observation bundle carrying every pipeline-register value out of pipe5_datapath.
interface pipe5_datapath_if;
  logic [31:0] pc, dinstOut;
  logic        ewreg, em2reg, ewmem, ealuimm;
  logic [3:0]  ealuc;
  logic [4:0]  edestReg;
  logic [31:0] eqa, eqb, eimm32;
  logic        mwreg, mm2reg, mwmem;
  logic [4:0]  mdestReg;
  logic [31:0] mr, mqb;
  logic        wwreg, wm2reg;
  logic [4:0]  wdestReg;
  logic [31:0] wr, wdo, qa, qb;

  modport master (
    output pc, dinstOut, ewreg, em2reg, ewmem, ealuimm, ealuc, edestReg, eqa, eqb, eimm32,
           mwreg, mm2reg, mwmem, mdestReg, mr, mqb, wwreg, wm2reg, wdestReg, wr, wdo, qa, qb
  );
  modport slave (
    input pc, dinstOut, ewreg, em2reg, ewmem, ealuimm, ealuc, edestReg, eqa, eqb, eimm32,
          mwreg, mm2reg, mwmem, mdestReg, mr, mqb, wwreg, wm2reg, wdestReg, wr, wdo, qa, qb
  );
endinterface

// File: rtl/pipe5_datapath_regfile.sv
// 32x32 register file: two combinational reads, falling-edge write, $0 hardwired to zero.
module pipe_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] qa,
  output logic [31:0] qb,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] regs [32];

  assign qa = (ra == 5'd0) ? 32'd0 : regs[ra];
  assign qb = (rb == 5'd0) ? 32'd0 : regs[rb];

  // Writing on the falling edge lets an ID read in the same cycle see the WB value
  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/pipe5_datapath.sv
// Five-stage in-order MIPS-subset datapath (no forwarding, no hazard detection, no branches).
module pipe5_datapath
  import pipe5_datapath_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter int          PROG       = 0
) (
  input  logic              clk,
  input  logic              resetn,
  pipe5_datapath_if.master  obs
);
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  for (genvar g = 0; g < IMEM_WORDS; g++) begin : g_rom
    assign imem[g] = imem_word(PROG, 6'(g));
  end

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  ctrl_t       ctrl_d;
  logic [4:0]  dest_d;
  logic [31:0] imm32_d, qa_d, qb_d, alu_b, alu_y, dmem_rd, wb_data;

  assign op      = obs.dinstOut[31:26];
  assign rs      = obs.dinstOut[25:21];
  assign rt      = obs.dinstOut[20:16];
  assign rd      = obs.dinstOut[15:11];
  assign funct   = obs.dinstOut[5:0];
  assign imm32_d = {{16{obs.dinstOut[15]}}, obs.dinstOut[15:0]};

  always_comb begin
    ctrl_d = '0;
    dest_d = '0;
    case (op)
      OP_RTYPE: begin
        ctrl_d.wreg = 1'b1;
        dest_d      = rd;
        case (funct)
          FN_ADD:  ctrl_d.aluc = ALU_ADD;
          FN_SUB:  ctrl_d.aluc = ALU_SUB;
          FN_AND:  ctrl_d.aluc = ALU_AND;
          FN_OR:   ctrl_d.aluc = ALU_OR;
          FN_XOR:  ctrl_d.aluc = ALU_XOR;
          FN_SLT:  ctrl_d.aluc = ALU_SLT;
          default: begin
            ctrl_d = '0;
            dest_d = '0;
          end
        endcase
      end
      OP_LW:   begin ctrl_d = '{1'b1, 1'b1, 1'b0, ALU_ADD, 1'b1}; dest_d = rt; end
      OP_SW:   begin ctrl_d = '{1'b0, 1'b0, 1'b1, ALU_ADD, 1'b1}; dest_d = rt; end
      OP_ADDI: begin ctrl_d = '{1'b1, 1'b0, 1'b0, ALU_ADD, 1'b1}; dest_d = rt; end
      default: ;
    endcase
  end

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic signed [31:0] a,
                                        input logic signed [31:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return {31'd0, (a < b)};
      default: return '0;
    endcase
  endfunction

  assign alu_b   = obs.ealuimm ? obs.eimm32 : obs.eqb;
  assign alu_y   = alu_f(obs.ealuc, obs.eqa, alu_b);
  assign dmem_rd = dmem[obs.mr[7:2]];
  assign wb_data = obs.wm2reg ? obs.wdo : obs.wr;
  assign obs.qa  = qa_d;
  assign obs.qb  = qb_d;

  pipe_regfile u_rf (
    .clk    (clk),
    .resetn (resetn),
    .ra     (rs),
    .rb     (rt),
    .qa     (qa_d),
    .qb     (qb_d),
    .we     (obs.wwreg),
    .waddr  (obs.wdestReg),
    .wdata  (wb_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= dmem_init(6'(i));
    end else if (obs.mwmem) begin
      dmem[obs.mr[7:2]] <= obs.mqb;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      obs.pc       <= RESET_PC;
      obs.dinstOut <= '0;
      obs.ewreg    <= 1'b0;
      obs.em2reg   <= 1'b0;
      obs.ewmem    <= 1'b0;
      obs.ealuc    <= '0;
      obs.ealuimm  <= 1'b0;
      obs.edestReg <= '0;
      obs.eqa      <= '0;
      obs.eqb      <= '0;
      obs.eimm32   <= '0;
      obs.mwreg    <= 1'b0;
      obs.mm2reg   <= 1'b0;
      obs.mwmem    <= 1'b0;
      obs.mdestReg <= '0;
      obs.mr       <= '0;
      obs.mqb      <= '0;
      obs.wwreg    <= 1'b0;
      obs.wm2reg   <= 1'b0;
      obs.wdestReg <= '0;
      obs.wr       <= '0;
      obs.wdo      <= '0;
    end else begin
      // IF -> ID
      obs.pc       <= obs.pc + 32'd4;
      obs.dinstOut <= imem[obs.pc[7:2]];
      // ID -> EXE
      obs.ewreg    <= ctrl_d.wreg;
      obs.em2reg   <= ctrl_d.m2reg;
      obs.ewmem    <= ctrl_d.wmem;
      obs.ealuc    <= ctrl_d.aluc;
      obs.ealuimm  <= ctrl_d.aluimm;
      obs.edestReg <= dest_d;
      obs.eqa      <= qa_d;
      obs.eqb      <= qb_d;
      obs.eimm32   <= imm32_d;
      // EXE -> MEM
      obs.mwreg    <= obs.ewreg;
      obs.mm2reg   <= obs.em2reg;
      obs.mwmem    <= obs.ewmem;
      obs.mdestReg <= obs.edestReg;
      obs.mr       <= alu_y;
      obs.mqb      <= obs.eqb;
      // MEM -> WB
      obs.wwreg    <= obs.mwreg;
      obs.wm2reg   <= obs.mm2reg;
      obs.wdestReg <= obs.mdestReg;
      obs.wr       <= obs.mr;
      obs.wdo      <= dmem_rd;
    end
  end
endmodule

// File: tb/tb_pipe5_datapath.sv
// Directed bench: the standard load program on one instance, the sw/$0/unknown-op program on another.
module tb_pipe5_datapath;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe5_datapath_if a ();
  pipe5_datapath_if b ();

  pipe5_datapath #(.PROG(0)) u_dut (.clk(clk), .resetn(resetn), .obs(a));
  pipe5_datapath #(.PROG(1)) u_alt (.clk(clk), .resetn(resetn), .obs(b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check("rst_pc",   a.pc, 32'd0);
    check("rst_inst", a.dinstOut, 32'd0);
    check("rst_ewreg", 32'(a.ewreg), 32'd0);
    check("rst_mr",   a.mr, 32'd0);
    check("rst_wdo",  a.wdo, 32'd0);
    #14 resetn = 1'b1;

    tick(); // edge 1
    check("e1_pc",     a.pc, 32'd4);
    check("e1_inst",   a.dinstOut, 32'h8C220000);
    check("e1_alt_inst", b.dinstOut, 32'h8C020000);

    tick(); // edge 2
    check("e2_ewreg",  32'(a.ewreg), 32'd1);
    check("e2_em2reg", 32'(a.em2reg), 32'd1);
    check("e2_ewmem",  32'(a.ewmem), 32'd0);
    check("e2_ealuc",  32'(a.ealuc), 32'd2);
    check("e2_ealuimm", 32'(a.ealuimm), 32'd1);
    check("e2_edest",  32'(a.edestReg), 32'd2);
    check("e2_eqa",    a.eqa, 32'd0);
    check("e2_eimm",   a.eimm32, 32'd0);

    tick(); // edge 3
    check("e3_mr",     a.mr, 32'd0);
    check("e3_mdest",  32'(a.mdestReg), 32'd2);
    check("e3_mwreg",  32'(a.mwreg), 32'd1);
    check("e3_alt_addi_wreg", 32'(b.ewreg), 32'd1);
    check("e3_alt_addi_dest", 32'(b.edestReg), 32'd0);
    check("e3_alt_addi_imm",  b.eimm32, 32'd5);

    tick(); // edge 4
    check("e4_wdo",    a.wdo, 32'hA00000AA);
    check("e4_wdest",  32'(a.wdestReg), 32'd2);
    check("e4_wm2reg", 32'(a.wm2reg), 32'd1);
    check("e4_alt_unk_ctrl", {27'd0, b.ewreg, b.em2reg, b.ewmem, b.ealuimm, 1'b0}, 32'd0);
    check("e4_alt_unk_aluc", 32'(b.ealuc), 32'd0);

    tick(); // edge 5: add $6,$2,$10 in ID; lw $2 retired at the previous falling edge
    check("e5_wdo",    a.wdo, 32'h10000011);
    check("e5_wdest",  32'(a.wdestReg), 32'd3);
    check("e5_inst",   a.dinstOut, 32'h004A3020);
    check("e5_qa",     a.qa, 32'hA00000AA);
    check("e5_qb",     a.qb, 32'd0);

    tick(); // edge 6
    check("e6_wdo",    a.wdo, 32'h20000022);
    check("e6_wdest",  32'(a.wdestReg), 32'd4);
    check("e6_add_ewreg", 32'(a.ewreg), 32'd1);
    check("e6_add_ealuc", 32'(a.ealuc), 32'd2);
    check("e6_add_aluimm", 32'(a.ealuimm), 32'd0);
    check("e6_add_edest", 32'(a.edestReg), 32'd6);
    check("e6_add_eqa",   a.eqa, 32'hA00000AA);
    check("e6_alt_sw_eqa", b.eqa, 32'd0);
    check("e6_alt_sw_eqb", b.eqb, 32'hA00000AA);

    tick(); // edge 7
    check("e7_wdo",    a.wdo, 32'h30000033);
    check("e7_wdest",  32'(a.wdestReg), 32'd5);
    check("e7_add_mr", a.mr, 32'hA00000AA);
    check("e7_alt_mwmem", 32'(b.mwmem), 32'd1);
    check("e7_alt_mr",    b.mr, 32'd16);
    check("e7_alt_mqb",   b.mqb, 32'hA00000AA);

    @(negedge clk); #1;
    check("rf_r2", u_dut.u_rf.regs[2], 32'hA00000AA);
    check("rf_r3", u_dut.u_rf.regs[3], 32'h10000011);
    check("rf_r4", u_dut.u_rf.regs[4], 32'h20000022);
    check("rf_r5", u_dut.u_rf.regs[5], 32'h30000033);
    check("rf_alt_r0", u_alt.u_rf.regs[0], 32'd0);

    tick(); // edge 8
    check("e8_add_wr",   a.wr, 32'hA00000AA);
    check("e8_add_wdest", 32'(a.wdestReg), 32'd6);
    check("e8_alt_lw_mr", b.mr, 32'd16);

    tick(); // edge 9
    check("e9_alt_lw_wdo",  b.wdo, 32'hA00000AA);
    check("e9_alt_lw_dest", 32'(b.wdestReg), 32'd7);
    check("e9_pc", a.pc, 32'd36);

    #2 resetn = 1'b0;
    #1;
    check("mid_rst_pc",     a.pc, 32'd0);
    check("mid_rst_alt_pc", b.pc, 32'd0);
    check("mid_rst_wdo",    b.wdo, 32'd0);
    check("mid_rst_wdest",  32'(b.wdestReg), 32'd0);
    check("mid_rst_rf",     u_dut.u_rf.regs[2], 32'd0);
    check("mid_rst_dmem",   u_alt.dmem[4], 32'h40000044);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
